// File: rtl/lsu_issue_arbiter.sv
// lsu_issue_arbiter: round-robin issue arbiter in front of the single LSU.
// A granted request is captured, handed to the LSU as a one-cycle
// lsu_request_o pulse, and tracked through the lsu_busy_i handshake until a
// tagged done pulse is reported.
// Optional build macro LSU_ARB_PERF_EN adds grant/stall performance counters;
// without it the perf ports read 0 and no counter logic exists.
//
// state        | meaning
// -------------+---------------------------------------------------------
// S_IDLE       | no op in flight; round-robin grant of a valid request
// S_ISSUE      | lsu_request_o high for one cycle, timeout counter loaded
// S_WAIT_START | waiting for lsu_busy_i to rise, bounded by START_TIMEOUT
// S_WAIT_DONE  | LSU busy; waiting for lsu_busy_i to fall
module lsu_issue_arbiter #(
  parameter int NUM_REQ       = 2,
  parameter int START_TIMEOUT = 4
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic [NUM_REQ-1:0]         req_valid_i,
  input  logic [NUM_REQ*32-1:0]      req_pc_i,
  input  logic [NUM_REQ*32-1:0]      req_inst_i,
  input  logic [NUM_REQ*32-1:0]      req_rs1_value_i,
  input  logic [NUM_REQ*32-1:0]      req_rs2_value_i,
  output logic [NUM_REQ-1:0]         req_accept_o,
  output logic                       lsu_request_o,
  output logic [31:0]                lsu_pc_o,
  output logic [31:0]                lsu_inst_o,
  output logic [31:0]                lsu_rs1_value_o,
  output logic [31:0]                lsu_rs2_value_o,
  input  logic                       lsu_busy_i,
  output logic                       done_o,
  output logic [$clog2(NUM_REQ)-1:0] done_id_o,
  output logic                       busy_o,
  output logic [31:0]                perf_grants_o,
  output logic [31:0]                perf_stall_o
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam int CW  = (START_TIMEOUT > 1) ? $clog2(START_TIMEOUT) : 1;

  // The ISSUE cycle counts as the first timeout cycle, so WAIT_START lasts
  // START_TIMEOUT-1 cycles (at least one, so busy is always sampled once).
  // done_o then lands START_TIMEOUT cycles after the lsu_request_o cycle.
  localparam logic [CW-1:0] TMO_LOAD = CW'((START_TIMEOUT >= 2) ? START_TIMEOUT - 2 : 0);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_START,
    S_WAIT_DONE
  } state_t;

  state_t          state;
  logic [IDW-1:0]  rr_ptr;
  logic [IDW-1:0]  act_id;
  logic [CW-1:0]   tmo_cnt;

  logic            grant_vld;
  logic [IDW-1:0]  grant_idx;

  logic [31:0]     pc_arr   [NUM_REQ];
  logic [31:0]     inst_arr [NUM_REQ];
  logic [31:0]     rs1_arr  [NUM_REQ];
  logic [31:0]     rs2_arr  [NUM_REQ];

  function automatic logic [IDW-1:0] next_ptr(input logic [IDW-1:0] g);
    if (g == IDW'(NUM_REQ - 1)) begin
      return '0;
    end
    return g + IDW'(1);
  endfunction

  // Unpack the flat requester buses into per-requester words.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      pc_arr[i]   = req_pc_i[32*i +: 32];
      inst_arr[i] = req_inst_i[32*i +: 32];
      rs1_arr[i]  = req_rs1_value_i[32*i +: 32];
      rs2_arr[i]  = req_rs2_value_i[32*i +: 32];
    end
  end

  // Round-robin pick: first valid requester at or after rr_ptr, wrapping.
  always_comb begin
    logic [IDW:0]   sum;
    logic [IDW-1:0] cand;
    grant_vld = 1'b0;
    grant_idx = '0;
    sum       = '0;
    cand      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum = {1'b0, rr_ptr} + (IDW+1)'(k);
      if (sum >= (IDW+1)'(NUM_REQ)) begin
        sum = sum - (IDW+1)'(NUM_REQ);
      end
      cand = sum[IDW-1:0];
      if (!grant_vld && req_valid_i[cand]) begin
        grant_vld = 1'b1;
        grant_idx = cand;
      end
    end
  end

  // Accept is only offered from IDLE and is forced low while reset is held.
  always_comb begin
    req_accept_o = '0;
    if (reset_i && (state == S_IDLE) && grant_vld) begin
      req_accept_o[grant_idx] = 1'b1;
    end
  end

  assign busy_o = (state != S_IDLE);

  // Arbitration/handshake FSM with registered request, capture and done outputs.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state           <= S_IDLE;
      rr_ptr          <= '0;
      act_id          <= '0;
      tmo_cnt         <= '0;
      lsu_request_o   <= 1'b0;
      lsu_pc_o        <= '0;
      lsu_inst_o      <= '0;
      lsu_rs1_value_o <= '0;
      lsu_rs2_value_o <= '0;
      done_o          <= 1'b0;
      done_id_o       <= '0;
    end else begin
      lsu_request_o <= 1'b0;
      done_o        <= 1'b0;
      done_id_o     <= '0;
      case (state)
        S_IDLE: begin
          if (grant_vld) begin
            lsu_pc_o        <= pc_arr[grant_idx];
            lsu_inst_o      <= inst_arr[grant_idx];
            lsu_rs1_value_o <= rs1_arr[grant_idx];
            lsu_rs2_value_o <= rs2_arr[grant_idx];
            act_id          <= grant_idx;
            rr_ptr          <= next_ptr(grant_idx);
            lsu_request_o   <= 1'b1;
            state           <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          tmo_cnt <= TMO_LOAD;
          state   <= S_WAIT_START;
        end
        S_WAIT_START: begin
          if (lsu_busy_i) begin
            state <= S_WAIT_DONE;
          end else if (tmo_cnt == '0) begin
            // LSU never acknowledged: treat the op as already complete.
            done_o    <= 1'b1;
            done_id_o <= act_id;
            state     <= S_IDLE;
          end else begin
            tmo_cnt <= tmo_cnt - CW'(1);
          end
        end
        S_WAIT_DONE: begin
          if (!lsu_busy_i) begin
            done_o    <= 1'b1;
            done_id_o <= act_id;
            state     <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

`ifdef LSU_ARB_PERF_EN
  logic [31:0] grants_q;
  logic [31:0] stall_q;

  // Grant count and cycles where someone is waiting but nobody is accepted.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      grants_q <= '0;
      stall_q  <= '0;
    end else begin
      if (|req_accept_o) begin
        grants_q <= grants_q + 32'd1;
      end
      if ((|req_valid_i) && !(|req_accept_o)) begin
        stall_q <= stall_q + 32'd1;
      end
    end
  end

  assign perf_grants_o = grants_q;
  assign perf_stall_o  = stall_q;
`else
  assign perf_grants_o = '0;
  assign perf_stall_o  = '0;
`endif

endmodule

// File: tb/tb_lsu_issue_arbiter.sv
// Scoreboard bench for lsu_issue_arbiter: directed stimulus pushes expected
// grants into a queue; a monitor pops and compares on accept/request/done.
module tb_lsu_issue_arbiter;

  localparam int NUM_REQ       = 2;
  localparam int START_TIMEOUT = 4;

  logic                  clk_i;
  logic                  reset_i;
  logic [NUM_REQ-1:0]    req_valid_i;
  logic [NUM_REQ*32-1:0] req_pc_i;
  logic [NUM_REQ*32-1:0] req_inst_i;
  logic [NUM_REQ*32-1:0] req_rs1_value_i;
  logic [NUM_REQ*32-1:0] req_rs2_value_i;
  logic [NUM_REQ-1:0]    req_accept_o;
  logic                  lsu_request_o;
  logic [31:0]           lsu_pc_o;
  logic [31:0]           lsu_inst_o;
  logic [31:0]           lsu_rs1_value_o;
  logic [31:0]           lsu_rs2_value_o;
  logic                  lsu_busy_i;
  logic                  done_o;
  logic [0:0]            done_id_o;
  logic                  busy_o;
  logic [31:0]           perf_grants_o;
  logic [31:0]           perf_stall_o;

  logic                  busy_man;
  logic                  busy_auto;
  logic                  lsu_auto;

  assign lsu_busy_i = busy_man | busy_auto;

  lsu_issue_arbiter #(
    .NUM_REQ       (NUM_REQ),
    .START_TIMEOUT (START_TIMEOUT)
  ) dut (
    .clk_i           (clk_i),
    .reset_i         (reset_i),
    .req_valid_i     (req_valid_i),
    .req_pc_i        (req_pc_i),
    .req_inst_i      (req_inst_i),
    .req_rs1_value_i (req_rs1_value_i),
    .req_rs2_value_i (req_rs2_value_i),
    .req_accept_o    (req_accept_o),
    .lsu_request_o   (lsu_request_o),
    .lsu_pc_o        (lsu_pc_o),
    .lsu_inst_o      (lsu_inst_o),
    .lsu_rs1_value_o (lsu_rs1_value_o),
    .lsu_rs2_value_o (lsu_rs2_value_o),
    .lsu_busy_i      (lsu_busy_i),
    .done_o          (done_o),
    .done_id_o       (done_id_o),
    .busy_o          (busy_o),
    .perf_grants_o   (perf_grants_o),
    .perf_stall_o    (perf_stall_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  typedef struct {
    int          id;
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] rs1;
    logic [31:0] rs2;
  } op_t;

  op_t exp_q[$];
  op_t fly_q[$];

  logic [31:0] pc_v  [NUM_REQ];
  logic [31:0] inst_v[NUM_REQ];
  logic [31:0] rs1_v [NUM_REQ];
  logic [31:0] rs2_v [NUM_REQ];

  int errors   = 0;
  int checks   = 0;
  int acc_cnt  = 0;
  int done_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, expv);
    end
  endtask

  task automatic fail_evt(input string name);
    checks++;
    errors++;
    $display("FAIL %s: event with empty scoreboard", name);
  endtask

  task automatic cyc_start();
    @(posedge clk_i);
    #1;
  endtask

  task automatic sample();
    @(negedge clk_i);
    #1;
  endtask

  task automatic set_req(input int i, input logic [31:0] pc, input logic [31:0] inst,
                         input logic [31:0] rs1, input logic [31:0] rs2);
    req_pc_i[32*i +: 32]        = pc;
    req_inst_i[32*i +: 32]      = inst;
    req_rs1_value_i[32*i +: 32] = rs1;
    req_rs2_value_i[32*i +: 32] = rs2;
    pc_v[i]   = pc;
    inst_v[i] = inst;
    rs1_v[i]  = rs1;
    rs2_v[i]  = rs2;
  endtask

  task automatic push_exp(input int id);
    op_t op;
    op.id   = id;
    op.pc   = pc_v[id];
    op.inst = inst_v[id];
    op.rs1  = rs1_v[id];
    op.rs2  = rs2_v[id];
    exp_q.push_back(op);
  endtask

  // Monitor: accept -> expected grant, request -> captured fields, done -> tag.
  initial begin
    forever begin
      @(negedge clk_i);
      if (reset_i) begin
        if (req_accept_o != '0) begin
          chk("accept_while_busy", 32'(busy_o), 32'd0);
          if (exp_q.size() == 0) begin
            fail_evt("unexpected_accept");
          end else begin
            op_t op;
            op = exp_q.pop_front();
            chk("accept_onehot", 32'(req_accept_o), 32'd1 << op.id);
            fly_q.push_back(op);
            acc_cnt++;
          end
        end
        if (lsu_request_o) begin
          if (fly_q.size() == 0) begin
            fail_evt("unexpected_request");
          end else begin
            chk("lsu_pc", lsu_pc_o, fly_q[0].pc);
            chk("lsu_inst", lsu_inst_o, fly_q[0].inst);
            chk("lsu_rs1", lsu_rs1_value_o, fly_q[0].rs1);
            chk("lsu_rs2", lsu_rs2_value_o, fly_q[0].rs2);
          end
        end
        if (done_o) begin
          if (fly_q.size() == 0) begin
            fail_evt("unexpected_done");
          end else begin
            op_t op;
            op = fly_q.pop_front();
            chk("done_id", 32'(done_id_o), 32'(op.id));
            done_cnt++;
          end
        end
      end
    end
  end

  // Simple LSU model: one busy cycle starting the cycle after each request.
  initial begin
    busy_auto = 1'b0;
    forever begin
      @(negedge clk_i);
      if (lsu_auto && lsu_request_o) begin
        @(posedge clk_i);
        #1;
        busy_auto = 1'b1;
        @(posedge clk_i);
        #1;
        busy_auto = 1'b0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    int last;
    int ba;
    int bd;

    reset_i         = 1'b0;
    req_valid_i     = '0;
    req_pc_i        = '0;
    req_inst_i      = '0;
    req_rs1_value_i = '0;
    req_rs2_value_i = '0;
    busy_man        = 1'b0;
    lsu_auto        = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) set_req(i, 32'h0, 32'h0, 32'h0, 32'h0);

    // Reset state
    sample();
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_lsu_pc", lsu_pc_o, 32'd0);
    chk("rst_perf_grants", perf_grants_o, 32'd0);
    cyc_start();
    reset_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      sample();
      chk("idle_busy", 32'(busy_o), 32'd0);
      chk("idle_request", 32'(lsu_request_o), 32'd0);
      chk("idle_accept", 32'(req_accept_o), 32'd0);
      chk("idle_done", 32'(done_o), 32'd0);
      cyc_start();
    end

    // Single SB op from requester 0, LSU busy for 3 cycles
    set_req(0, 32'h0000_1000, 32'h0020_8223, 32'h0, 32'h0000_FFFF);
    req_valid_i = 2'b01;
    push_exp(0);
    sample();
    chk("t2_accept", 32'(req_accept_o), 32'h1);
    cyc_start();                       // c1
    req_valid_i = 2'b00;
    set_req(0, 32'hDEAD_BEEF, 32'h0, 32'h1, 32'h2);
    sample();
    chk("t2_request", 32'(lsu_request_o), 32'd1);
    cyc_start();                       // c2
    busy_man = 1'b1;
    sample();
    chk("t2_request_pulse", 32'(lsu_request_o), 32'd0);
    cyc_start();                       // c3
    cyc_start();                       // c4
    sample();
    chk("t2_pc_held", lsu_pc_o, 32'h0000_1000);
    chk("t2_inst_held", lsu_inst_o, 32'h0020_8223);
    chk("t2_busy", 32'(busy_o), 32'd1);
    cyc_start();                       // c5
    busy_man = 1'b0;
    sample();
    chk("t2_no_early_done", 32'(done_o), 32'd0);
    cyc_start();                       // c6
    sample();
    chk("t2_done", 32'(done_o), 32'd1);
    chk("t2_busy_clear", 32'(busy_o), 32'd0);
    cyc_start();                       // c7
    sample();
    chk("t2_done_pulse", 32'(done_o), 32'd0);

    // Fresh reset so the round-robin pointer starts at requester 0
    cyc_start();
    reset_i = 1'b0;
    cyc_start();
    reset_i = 1'b1;
    exp_q.delete();
    fly_q.delete();

    // Both requesters always valid: grants 0,1,0,1 every 4 cycles
    cyc_start();                       // c0
    set_req(0, 32'h0000_0100, 32'h0020_8223, 32'h0000_0010, 32'h0000_0055);
    set_req(1, 32'h0000_0200, 32'h0040_0183, 32'h0000_0020, 32'h0000_0000);
    req_valid_i = 2'b11;
    lsu_auto    = 1'b1;
    push_exp(0);
    push_exp(1);
    push_exp(0);
    push_exp(1);
    ba   = acc_cnt;
    bd   = done_cnt;
    c    = 0;
    last = -1;
    while (c < 40) begin
      sample();
      if (done_cnt - bd >= 4) begin
        last = c;
        break;
      end
      cyc_start();
      c++;
      if (acc_cnt - ba >= 4) req_valid_i = 2'b00;
    end
    chk("t3_last_done_cycle", 32'(last), 32'd16);
    chk("t3_grant_count", 32'(acc_cnt - ba), 32'd4);
`ifdef LSU_ARB_PERF_EN
    chk("perf_grants", perf_grants_o, 32'd4);
    chk("perf_stall", perf_stall_o, 32'd9);
`else
    chk("perf_grants_off", perf_grants_o, 32'd0);
    chk("perf_stall_off", perf_stall_o, 32'd0);
`endif

    // LSU never responds: timeout completion plus same-cycle next grant
    cyc_start();                       // c0
    lsu_auto    = 1'b0;
    req_valid_i = 2'b11;
    push_exp(0);
    push_exp(1);
    sample();
    chk("t4_accept", 32'(req_accept_o), 32'h1);
    cyc_start();                       // c1
    req_valid_i = 2'b10;
    sample();
    chk("t4_request", 32'(lsu_request_o), 32'd1);
    for (int k = 2; k <= 5; k++) begin
      cyc_start();
      sample();
      chk("t4_done_timing", 32'(done_o), 32'(k == 5));
    end
    chk("t4_b2b_accept", 32'(req_accept_o), 32'h2);
    cyc_start();                       // c6
    req_valid_i = 2'b00;
    sample();
    chk("t4_request2", 32'(lsu_request_o), 32'd1);
    for (int k = 7; k <= 10; k++) begin
      cyc_start();
      sample();
      chk("t4_done2_timing", 32'(done_o), 32'(k == 10));
    end

    // Reset during WAIT_DONE discards the op; restart grants requester 0
    cyc_start();                       // c0
    req_valid_i = 2'b10;
    push_exp(1);
    sample();
    chk("t5_accept", 32'(req_accept_o), 32'h2);
    cyc_start();                       // c1
    req_valid_i = 2'b00;
    cyc_start();                       // c2
    busy_man = 1'b1;
    cyc_start();                       // c3
    sample();
    chk("t5_in_wait_done", 32'(busy_o), 32'd1);
    reset_i = 1'b0;
    #1;
    chk("t5_rst_busy", 32'(busy_o), 32'd0);
    chk("t5_rst_done", 32'(done_o), 32'd0);
    chk("t5_rst_request", 32'(lsu_request_o), 32'd0);
    chk("t5_rst_pc", lsu_pc_o, 32'd0);
    chk("t5_rst_rs1", lsu_rs1_value_o, 32'd0);
    exp_q.delete();
    fly_q.delete();
    cyc_start();
    busy_man = 1'b0;
    cyc_start();
    reset_i = 1'b1;
    sample();
    chk("t5_no_done", 32'(done_o), 32'd0);
    cyc_start();                       // c0
    req_valid_i = 2'b11;
    lsu_auto    = 1'b1;
    push_exp(0);
    sample();
    chk("t5_restart_accept", 32'(req_accept_o), 32'h1);
    cyc_start();                       // c1
    req_valid_i = 2'b00;
    bd   = done_cnt;
    c    = 1;
    last = -1;
    while (c < 12) begin
      sample();
      if (done_cnt > bd) begin
        last = c;
        break;
      end
      cyc_start();
      c++;
    end
    chk("t5_done_cycle", 32'(last), 32'd4);

    cyc_start();
    cyc_start();
    sample();
    chk("final_exp_empty", 32'(exp_q.size()), 32'd0);
    chk("final_fly_empty", 32'(fly_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
